// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared types and constants for the pipeline hazard scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  localparam int REG_AW_DEF = 3;
  // Entry tags are stored at a fixed maximum width; narrower register
  // addresses are zero-extended, which keeps equality exact.
  localparam int DEST_MAXW  = 8;
  localparam int CNT_W      = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic                 v;
    logic                 we;
    logic [DEST_MAXW-1:0] dest;
    logic                 ld;
  } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/sb_match.sv
`default_nettype none
// ============================================================================
// Module   : sb_match
// Brief    : Single-entry RAW comparator: does this in-flight writer feed the
//            Rs/Rt operand of the instruction currently in ID?
// Revision : 1.0 - initial release
// ============================================================================
module sb_match
  import pipe_pkg::*;
(
  input  logic                 i_v,
  input  logic                 i_we,
  input  logic [DEST_MAXW-1:0] i_dest,
  input  logic                 i_id_valid,
  input  logic                 i_rd_rs,
  input  logic [DEST_MAXW-1:0] i_rs,
  input  logic                 i_rd_rt,
  input  logic [DEST_MAXW-1:0] i_rt,
  output logic                 o_match_rs,
  output logic                 o_match_rt
);

  logic w_live;

  assign w_live     = i_id_valid & i_v & i_we;
  assign o_match_rs = w_live & i_rd_rs & (i_dest == i_rs);
  assign o_match_rt = w_live & i_rd_rt & (i_dest == i_rt);

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Tracks in-flight destination tags for DEPTH post-decode stages and
//            produces stall, PC/IF_ID write enables and forwarding selects.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int DEPTH     = 3,
  parameter int REG_AW    = 3,
  parameter int FWD_EN    = 0,
  parameter int RF_BYPASS = 1,
  parameter int FLUSH_IDX = 1,
  parameter int SELW      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid_i,
  input  logic              id_wr_en_i,
  input  logic [REG_AW-1:0] id_dest_i,
  input  logic              id_is_load_i,
  input  logic              id_rd_rs_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic              id_rd_rt_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              flush_i,
  input  logic              mem_stall_i,
  input  logic              clr_cnt_i,
  output logic              stall_o,
  output logic              pc_we_o,
  output logic              ifid_we_o,
  output logic [SELW-1:0]   fwd_rs_sel_o,
  output logic [SELW-1:0]   fwd_rt_sel_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  sb_entry_t            r_entry [DEPTH];
  logic [CNT_W-1:0]     r_cnt;

  logic [DEPTH-1:0]     w_m_rs;
  logic [DEPTH-1:0]     w_m_rt;
  logic [DEPTH-1:0]     w_valid;
  logic [DEST_MAXW-1:0] w_rs;
  logic [DEST_MAXW-1:0] w_rt;
  logic                 w_raw_any;
  logic                 w_load_use;
  logic                 w_stall;
  logic [SELW-1:0]      w_rs_sel;
  logic [SELW-1:0]      w_rt_sel;

  assign w_rs = DEST_MAXW'(id_rs_i);
  assign w_rt = DEST_MAXW'(id_rt_i);

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_match
      sb_match u_match (
        .i_v        (r_entry[k].v),
        .i_we       (r_entry[k].we),
        .i_dest     (r_entry[k].dest),
        .i_id_valid (id_valid_i),
        .i_rd_rs    (id_rd_rs_i),
        .i_rs       (w_rs),
        .i_rd_rt    (id_rd_rt_i),
        .i_rt       (w_rt),
        .o_match_rs (w_m_rs[k]),
        .o_match_rt (w_m_rt[k])
      );
      assign w_valid[k] = r_entry[k].v;
    end
  endgenerate

  // With a write-through register file the oldest entry is already visible.
  always_comb begin
    w_raw_any = 1'b0;
    for (int k = 0; k <= DEPTH - 1 - RF_BYPASS; k++) begin
      w_raw_any = w_raw_any | w_m_rs[k] | w_m_rt[k];
    end
  end

  assign w_load_use = (w_m_rs[0] | w_m_rt[0]) & r_entry[0].ld;
  assign w_stall    = ~flush_i & ((FWD_EN != 0) ? w_load_use : w_raw_any);

  // Descending scan so the youngest matching writer wins; a load still in EX
  // has no data yet and is never a forwarding source.
  always_comb begin
    w_rs_sel = '0;
    w_rt_sel = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (w_m_rs[k] && !(k == 0 && r_entry[0].ld)) w_rs_sel = SELW'(k + 1);
      if (w_m_rt[k] && !(k == 0 && r_entry[0].ld)) w_rt_sel = SELW'(k + 1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) r_entry[k] <= '0;
    end else if (!mem_stall_i) begin
      r_entry[0].v    <= id_valid_i & ~w_stall & ~flush_i;
      r_entry[0].we   <= id_wr_en_i;
      r_entry[0].dest <= DEST_MAXW'(id_dest_i);
      r_entry[0].ld   <= id_is_load_i;
      for (int k = 1; k < DEPTH; k++) begin
        r_entry[k] <= r_entry[k-1];
        if (flush_i && k <= FLUSH_IDX) r_entry[k].v <= 1'b0;
      end
    end else if (flush_i) begin
      // Frozen pipe: squash the younger instructions where they sit.
      for (int k = 0; k < FLUSH_IDX; k++) r_entry[k].v <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr_cnt_i) begin
      r_cnt <= '0;
    end else if (w_stall && !mem_stall_i && r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign stall_o      = w_stall;
  assign pc_we_o      = ~w_stall & ~mem_stall_i;
  assign ifid_we_o    = ~w_stall & ~mem_stall_i;
  assign fwd_rs_sel_o = (FWD_EN != 0) ? w_rs_sel : '0;
  assign fwd_rt_sel_o = (FWD_EN != 0) ? w_rt_sel : '0;
  assign busy_o       = |w_valid;
  assign stall_cnt_o  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Bench for hazard_scoreboard: three configurations share stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

  logic       clk;
  logic       rst;
  logic       id_valid, id_we, id_ld, id_rd_rs, id_rd_rt;
  logic [2:0] id_dest, id_rs, id_rt;
  logic       flush, mem_stall, clr;

  logic       so_stall, so_pcwe, so_ifidwe, so_busy;
  logic [1:0] so_rs, so_rt;
  logic [15:0] so_cnt;
  logic       fw_stall, fw_pcwe, fw_ifidwe, fw_busy;
  logic [1:0] fw_rs, fw_rt;
  logic [15:0] fw_cnt;
  logic       st_stall, st_pcwe, st_ifidwe, st_busy;
  logic [3:0] st_rs, st_rt;
  logic [15:0] st_cnt;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard u_so (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_wr_en_i(id_we), .id_dest_i(id_dest),
    .id_is_load_i(id_ld), .id_rd_rs_i(id_rd_rs), .id_rs_i(id_rs), .id_rd_rt_i(id_rd_rt),
    .id_rt_i(id_rt), .flush_i(flush), .mem_stall_i(mem_stall), .clr_cnt_i(clr),
    .stall_o(so_stall), .pc_we_o(so_pcwe), .ifid_we_o(so_ifidwe), .fwd_rs_sel_o(so_rs),
    .fwd_rt_sel_o(so_rt), .busy_o(so_busy), .stall_cnt_o(so_cnt)
  );

  hazard_scoreboard #(.FWD_EN(1)) u_fw (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_wr_en_i(id_we), .id_dest_i(id_dest),
    .id_is_load_i(id_ld), .id_rd_rs_i(id_rd_rs), .id_rs_i(id_rs), .id_rd_rt_i(id_rd_rt),
    .id_rt_i(id_rt), .flush_i(flush), .mem_stall_i(mem_stall), .clr_cnt_i(clr),
    .stall_o(fw_stall), .pc_we_o(fw_pcwe), .ifid_we_o(fw_ifidwe), .fwd_rs_sel_o(fw_rs),
    .fwd_rt_sel_o(fw_rt), .busy_o(fw_busy), .stall_cnt_o(fw_cnt)
  );

  hazard_scoreboard #(.DEPTH(8), .RF_BYPASS(0)) u_st (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_wr_en_i(id_we), .id_dest_i(id_dest),
    .id_is_load_i(id_ld), .id_rd_rs_i(id_rd_rs), .id_rs_i(id_rs), .id_rd_rt_i(id_rd_rt),
    .id_rt_i(id_rt), .flush_i(flush), .mem_stall_i(mem_stall), .clr_cnt_i(clr),
    .stall_o(st_stall), .pc_we_o(st_pcwe), .ifid_we_o(st_ifidwe), .fwd_rs_sel_o(st_rs),
    .fwd_rt_sel_o(st_rt), .busy_o(st_busy), .stall_cnt_o(st_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: list of in-flight instructions per configuration,
  // index 0 = youngest (EX).
  typedef struct { bit v; bit we; int dest; bit ld; } ment_t;
  ment_t       m [3][8];
  int unsigned mcnt [3];
  int P_DEPTH [3] = '{3, 3, 8};
  int P_FWD   [3] = '{0, 1, 0};
  int P_BYP   [3] = '{1, 1, 0};
  int P_FI    [3] = '{1, 1, 1};
  string FN   [7] = '{"stall", "pc_we", "ifid_we", "fwd_rs", "fwd_rt", "busy", "cnt"};

  function automatic bit m_hit(int i, int k, bit rd, int a);
    return id_valid && rd && m[i][k].v && m[i][k].we && (m[i][k].dest == a);
  endfunction

  function automatic bit m_stall(int i);
    bit s = 1'b0;
    if (flush) return 1'b0;
    if (P_FWD[i] != 0) return (m_hit(i, 0, id_rd_rs, id_rs) || m_hit(i, 0, id_rd_rt, id_rt)) && m[i][0].ld;
    for (int k = 0; k < P_DEPTH[i] - P_BYP[i]; k++)
      s = s | m_hit(i, k, id_rd_rs, id_rs) | m_hit(i, k, id_rd_rt, id_rt);
    return s;
  endfunction

  function automatic int m_sel(int i, bit rd, int a);
    if (P_FWD[i] == 0) return 0;
    for (int k = 0; k < P_DEPTH[i]; k++)
      if (m_hit(i, k, rd, a) && !(k == 0 && m[i][0].ld)) return k + 1;
    return 0;
  endfunction

  function automatic logic [31:0] model_val(int i, int f);
    bit any = 1'b0;
    case (f)
      0: return 32'(m_stall(i));
      1, 2: return 32'(!m_stall(i) && !mem_stall);
      3: return 32'(m_sel(i, id_rd_rs, id_rs));
      4: return 32'(m_sel(i, id_rd_rt, id_rt));
      5: begin
        for (int k = 0; k < P_DEPTH[i]; k++) any = any | m[i][k].v;
        return 32'(any);
      end
      default: return 32'(mcnt[i]);
    endcase
  endfunction

  function automatic logic [31:0] dut_val(int i, int f);
    case (i)
      0: case (f) 0: return 32'(so_stall); 1: return 32'(so_pcwe); 2: return 32'(so_ifidwe);
           3: return 32'(so_rs); 4: return 32'(so_rt); 5: return 32'(so_busy); default: return 32'(so_cnt); endcase
      1: case (f) 0: return 32'(fw_stall); 1: return 32'(fw_pcwe); 2: return 32'(fw_ifidwe);
           3: return 32'(fw_rs); 4: return 32'(fw_rt); 5: return 32'(fw_busy); default: return 32'(fw_cnt); endcase
      default: case (f) 0: return 32'(st_stall); 1: return 32'(st_pcwe); 2: return 32'(st_ifidwe);
           3: return 32'(st_rs); 4: return 32'(st_rt); 5: return 32'(st_busy); default: return 32'(st_cnt); endcase
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mcnt[i] = 0;
      for (int k = 0; k < 8; k++) m[i][k] = '{1'b0, 1'b0, 0, 1'b0};
    end
  endtask

  task automatic model_clock();
    bit st [3];
    for (int i = 0; i < 3; i++) st[i] = m_stall(i);
    for (int i = 0; i < 3; i++) begin
      if (clr) mcnt[i] = 0;
      else if (st[i] && !mem_stall && mcnt[i] < 65535) mcnt[i]++;
      if (!mem_stall) begin
        for (int k = P_DEPTH[i] - 1; k >= 1; k--) m[i][k] = m[i][k-1];
        m[i][0] = '{id_valid && !st[i] && !flush, id_we, int'(id_dest), id_ld};
        if (flush) for (int k = 0; k <= P_FI[i]; k++) m[i][k].v = 1'b0;
      end else if (flush) begin
        for (int k = 0; k < P_FI[i]; k++) m[i][k].v = 1'b0;
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) model_clock();
    else model_reset();
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_we = 0; id_ld = 0; id_rd_rs = 0; id_rd_rt = 0;
    id_dest = 0; id_rs = 0; id_rt = 0; flush = 0; mem_stall = 0; clr = 0;
  endtask

  task automatic set_id(bit v, bit we, int d, bit ld, bit rrs, int rs, bit rrt, int rt);
    id_valid = v; id_we = we; id_dest = 3'(d); id_ld = ld;
    id_rd_rs = rrs; id_rs = 3'(rs); id_rd_rt = rrt; id_rt = 3'(rt);
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    model_reset();
    advance();
    advance();
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    model_reset();
    set_id(1, 1, 3, 0, 1, 3, 1, 3);
    mem_stall = 1;
    #1;
    checks++; if (so_pcwe !== 1'b0 || st_ifidwe !== 1'b0) begin errors++;
      $display("FAIL reset_pcwe_memstall got %b/%b exp 0/0", so_pcwe, st_ifidwe); end
    mem_stall = 0;
    #1;
    checks++; if (so_pcwe !== 1'b1 || fw_ifidwe !== 1'b1) begin errors++;
      $display("FAIL reset_pcwe got %b/%b exp 1/1", so_pcwe, fw_ifidwe); end
    checks++; if ({so_stall, so_busy, so_rs, so_rt, fw_stall, fw_busy, fw_rs, fw_rt, st_stall, st_busy} !== '0) begin errors++;
      $display("FAIL reset_outputs got %b exp 0", {so_stall, so_busy, so_rs, so_rt, fw_stall, fw_busy, fw_rs, fw_rt, st_stall, st_busy}); end
    checks++; if (so_cnt !== 16'd0 || st_cnt !== 16'd0) begin errors++;
      $display("FAIL reset_cnt got %0h/%0h exp 0", so_cnt, st_cnt); end
    advance();
    advance();
    rst = 1;
    idle();
  endtask

  task automatic test_stall_only();
    bit exp_st [3] = '{1'b1, 1'b1, 1'b0};
    do_reset();
    set_id(1, 1, 3, 0, 0, 0, 0, 0);
    advance();
    set_id(1, 0, 0, 0, 1, 3, 0, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (so_stall !== exp_st[c] || so_pcwe !== !exp_st[c]) begin errors++;
        $display("FAIL so_raw_cycle%0d stall/pcwe got %b/%b exp %b/%b", c, so_stall, so_pcwe, exp_st[c], !exp_st[c]); end
      advance();
    end
    idle();
    #1;
    checks++; if (so_cnt !== 16'd2) begin errors++;
      $display("FAIL so_stall_cnt got %0d exp 2", so_cnt); end
  endtask

  task automatic test_forward();
    do_reset();
    set_id(1, 1, 5, 0, 0, 0, 0, 0);
    advance();
    set_id(1, 0, 0, 0, 0, 0, 1, 5);
    #1;
    checks++; if (fw_stall !== 1'b0 || fw_rt !== 2'd1) begin errors++;
      $display("FAIL fw_gap0 stall/sel got %b/%0d exp 0/1", fw_stall, fw_rt); end
    do_reset();
    set_id(1, 1, 5, 0, 0, 0, 0, 0);
    advance();
    idle();
    advance();
    set_id(1, 0, 0, 0, 0, 0, 1, 5);
    #1;
    checks++; if (fw_stall !== 1'b0 || fw_rt !== 2'd2 || fw_rs !== 2'd0) begin errors++;
      $display("FAIL fw_gap1 stall/rt/rs got %b/%0d/%0d exp 0/2/0", fw_stall, fw_rt, fw_rs); end
    idle();
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1, 1, 2, 1, 0, 0, 0, 0);
    advance();
    set_id(1, 0, 0, 0, 1, 2, 0, 0);
    #1;
    checks++; if (fw_stall !== 1'b1 || fw_pcwe !== 1'b0 || fw_rs !== 2'd0) begin errors++;
      $display("FAIL ld_use_bubble stall/pcwe/sel got %b/%b/%0d exp 1/0/0", fw_stall, fw_pcwe, fw_rs); end
    advance();
    #1;
    checks++; if (fw_stall !== 1'b0 || fw_rs !== 2'd2 || fw_cnt !== 16'd1) begin errors++;
      $display("FAIL ld_use_fwd stall/sel/cnt got %b/%0d/%0d exp 0/2/1", fw_stall, fw_rs, fw_cnt); end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    set_id(1, 0, 0, 0, 0, 0, 0, 0);
    advance();
    set_id(1, 1, 4, 0, 0, 0, 0, 0);
    advance();
    set_id(1, 0, 0, 0, 1, 4, 0, 0);
    #1;
    checks++; if (so_stall !== 1'b1) begin errors++;
      $display("FAIL flush_pre_hazard got %b exp 1", so_stall); end
    flush = 1;
    #1;
    checks++; if (so_stall !== 1'b0 || so_pcwe !== 1'b1) begin errors++;
      $display("FAIL flush_same_cycle stall/pcwe got %b/%b exp 0/1", so_stall, so_pcwe); end
    advance();
    flush = 0;
    #1;
    checks++; if (so_stall !== 1'b0 || so_busy !== 1'b1) begin errors++;
      $display("FAIL flush_after stall/busy got %b/%b exp 0/1", so_stall, so_busy); end
    idle();
  endtask

  task automatic test_mem_stall();
    bit exp_st [3] = '{1'b1, 1'b1, 1'b0};
    do_reset();
    set_id(1, 1, 3, 0, 0, 0, 0, 0);
    advance();
    set_id(1, 0, 0, 0, 1, 3, 0, 0);
    mem_stall = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (so_stall !== 1'b1 || so_pcwe !== 1'b0 || so_cnt !== 16'd0 || so_busy !== 1'b1) begin errors++;
        $display("FAIL freeze_cycle%0d stall/pcwe/cnt/busy got %b/%b/%0d/%b exp 1/0/0/1", c, so_stall, so_pcwe, so_cnt, so_busy); end
      advance();
    end
    mem_stall = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (so_stall !== exp_st[c]) begin errors++;
        $display("FAIL freeze_resume%0d stall got %b exp %b", c, so_stall, exp_st[c]); end
      advance();
    end
    idle();
    #1;
    checks++; if (so_cnt !== 16'd2) begin errors++;
      $display("FAIL freeze_cnt got %0d exp 2", so_cnt); end
  endtask

  task automatic test_random();
    logic [31:0] e, g;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      set_id($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
             $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
             $urandom_range(0, 1) == 1, $urandom_range(0, 3));
      flush     = ($urandom_range(0, 7) == 0);
      mem_stall = ($urandom_range(0, 5) == 0);
      clr       = ($urandom_range(0, 31) == 0);
      #1;
      for (int i = 0; i < 3; i++) begin
        for (int f = 0; f < 7; f++) begin
          e = model_val(i, f);
          g = dut_val(i, f);
          checks++;
          if (g !== e) begin
            errors++;
            $display("FAIL rand_c%0d_inst%0d_%s got %0h exp %0h", c, i, FN[f], g, e);
          end
        end
      end
      advance();
    end
    idle();
  endtask

  task automatic test_saturation();
    int n;
    do_reset();
    set_id(1, 1, 1, 0, 1, 1, 0, 0);
    for (int c = 0; c < 80000 && mcnt[2] != 32'hFFFE; c++) advance();
    #1;
    checks++; if (st_cnt !== 16'hFFFE) begin errors++;
      $display("FAIL sat_preload got %0h exp fffe", st_cnt); end
    n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      if (m_stall(2)) n++;
      advance();
    end
    #1;
    checks++; if (st_cnt !== 16'hFFFF || n != 3) begin errors++;
      $display("FAIL sat_hold got %0h exp ffff (stalls seen %0d exp 3)", st_cnt, n); end
    clr = 1;
    #1;
    checks++; if (st_cnt !== 16'hFFFF) begin errors++;
      $display("FAIL clr_sync got %0h exp ffff", st_cnt); end
    advance();
    clr = 0;
    #1;
    checks++; if (st_cnt !== 16'd0) begin errors++;
      $display("FAIL clr_cnt got %0h exp 0", st_cnt); end
    for (int c = 0; c < 20 && !m_stall(2); c++) advance();
    #1;
    checks++; if (st_stall !== 1'b1) begin errors++;
      $display("FAIL pre_rst_stall got %b exp 1", st_stall); end
    rst = 0;
    model_reset();
    #1;
    checks++; if (st_busy !== 1'b0 || st_stall !== 1'b0 || so_busy !== 1'b0 || st_cnt !== 16'd0) begin errors++;
      $display("FAIL async_rst busy/stall/so_busy/cnt got %b/%b/%b/%0h exp 0/0/0/0", st_busy, st_stall, so_busy, st_cnt); end
    advance();
    rst = 1;
    #1;
    checks++; if (st_stall !== 1'b0 || st_pcwe !== 1'b1) begin errors++;
      $display("FAIL post_rst_empty stall/pcwe got %b/%b exp 0/1", st_stall, st_pcwe); end
    advance();
    #1;
    checks++; if (st_stall !== 1'b1 || st_busy !== 1'b1) begin errors++;
      $display("FAIL post_rst_first stall/busy got %b/%b exp 1/1", st_stall, st_busy); end
    idle();
  endtask

  initial begin
    rst = 1;
    idle();
    model_reset();
    #2;
    test_reset();
    test_stall_only();
    test_forward();
    test_load_use();
    test_flush();
    test_mem_stall();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
